ccr_flag_unit: RTL and testbench
================================

Name: ccr_flag_unit

Overview:
- Condition-code register stage directly downstream of the ALU.
- Registers the ALU's combinational {V,C,N,Z} flag output and feeds it back as the ALU's current-flags input.
- Evaluates conditional jumps (JZ/JN/JC/JV) against forwarded flags, clears the tested flag when the jump is taken, and saves/restores flags across interrupt entry and RTI.

Parameters:
- CCR_WIDTH, 4, flag vector width, fixed order {V,C,N,Z} (bit3..bit0).
- JSEL_WIDTH, 2, jump-condition select width.
- SHADOW_DEPTH, 4, shadow stack depth; used only when CCR_SHADOW_STACK_EN is defined.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- stall  input  1  pipeline stall; freezes all state.
- alu_ccr  input  CCR_WIDTH  flag result from the ALU this cycle.
- ccr_we  input  1  commit alu_ccr this cycle.
- jmp_valid  input  1  conditional-jump instruction is being resolved.
- jmp_sel  input  JSEL_WIDTH  jump condition: 00 JZ (bit0), 01 JN (bit1), 10 JC (bit2), 11 JV (bit3).
- int_save  input  1  interrupt entry; push the committed flags.
- rti_restore  input  1  RTI; pop flags into the CCR.
- ccr_out  output  CCR_WIDTH  registered CCR; drives the ALU current-flags input.
- branch_taken  output  1  combinational jump decision.
- shadow_valid  output  1  at least one saved flag set is held.
- shadow_ovf  output  1  sticky: a save occurred with the shadow full.

Behaviour:
- Reset (async, rst=1): ccr_out=0, shadow storage=0, shadow_valid=0, shadow_ovf=0, branch_taken=0. rst overrides every other input.
- Forwarded flags: eff = ccr_we ? alu_ccr : ccr_out.
  - Used for jump evaluation, so a jump directly after an ALU op sees that op's flags.
- branch_taken (combinational):
  - = jmp_valid & eff[bit(jmp_sel)] & ~stall & ~rti_restore & ~rst.
- Next CCR (nxt):
  - Start from eff.
  - If branch_taken, clear the tested bit in nxt; all other bits pass through.
- Priority each clock edge, highest first:
  1. stall=1: every register holds; int_save and rti_restore are ignored.
  2. rti_restore=1:
     - ccr_out <= shadow top, or 0 if shadow_valid=0 (shadow_ovf unchanged).
     - Shadow pops.
     - ccr_we, jmp_valid and int_save are ignored that cycle.
  3. Otherwise: ccr_out <= nxt.
     - If int_save=1, the shadow captures nxt, i.e. the value committed on that same edge.
- Latency: alu_ccr with ccr_we=1 appears on ccr_out one edge later; branch_taken has zero latency.
- Single-entry shadow (default build):
  - A save sets shadow_valid=1.
  - A save while shadow_valid=1 overwrites the entry and sets shadow_ovf.
  - A restore clears shadow_valid.
- shadow_ovf clears only on rst.
- No combinational path from ccr_out back to ccr_out; all outputs except branch_taken are flop outputs.

Optional Feature:
- Macro: CCR_SHADOW_STACK_EN.
- Defined:
  - Shadow is a LIFO of SHADOW_DEPTH entries with a pointer of clog2(SHADOW_DEPTH)+1 bits.
  - Push on save, pop on restore; shadow_valid = (pointer != 0).
  - Push when full: overwrites the top entry, sets shadow_ovf, pointer unchanged.
  - Pop when empty: loads 0, pointer stays 0.
  - Nested interrupts restore in reverse order.
- Undefined: single-entry shadow as described above; SHADOW_DEPTH is ignored.

Test Plan:
- Reset mid-operation:
  - Stimulus: ccr_out=4'b1111 with shadow_valid=1; pulse rst asynchronously between edges.
  - Required: ccr_out=0, shadow_valid=0, shadow_ovf=0 immediately, with no clock edge needed.
- Forwarded jump:
  - Stimulus: ccr_out=0; ccr_we=1, alu_ccr=4'b0001, jmp_valid=1, jmp_sel=00 in the same cycle.
  - Required: branch_taken=1 that cycle; ccr_out=4'b0000 after the edge (Z cleared).
- Jump not taken:
  - Stimulus: ccr_out=4'b0100, jmp_sel=01 (JN).
  - Required: branch_taken=0; ccr_out stays 4'b0100.
  - Then jmp_sel=10 (JC): branch_taken=1 and ccr_out becomes 4'b0000.
- Stall:
  - Stimulus: stall=1 with ccr_we=1, alu_ccr=4'b1010, jmp_valid=1, int_save=1.
  - Required: branch_taken=0; ccr_out, shadow_valid and shadow contents unchanged after 3 edges.
- Save/restore:
  - Stimulus: ccr_out=4'b0110; int_save=1 with ccr_we=1, alu_ccr=4'b1001 on one edge. Then ccr_we=1, alu_ccr=4'b0000. Then rti_restore=1 together with ccr_we=1, alu_ccr=4'b1111.
  - Required: ccr_out returns to 4'b1001 (alu_ccr ignored on the RTI cycle); shadow_valid=0.
- Overflow:
  - Default build: two saves without a restore set shadow_ovf=1.
  - With CCR_SHADOW_STACK_EN: saves of 1,2,3,4 then four restores yield 4,3,2,1 with shadow_ovf=0; a fifth save when full sets shadow_ovf=1.

Source files
------------

// File: rtl/ccr_flag_unit.sv
// Condition-code register behind the ALU: forwarded jump evaluation, taken-flag clear,
// and flag save/restore across interrupts. Define CCR_SHADOW_STACK_EN for a nested LIFO shadow.
module ccr_flag_unit #(
    parameter int CCR_WIDTH    = 4,
    parameter int JSEL_WIDTH   = 2,
    parameter int SHADOW_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic [CCR_WIDTH-1:0]  alu_ccr,
    input  logic                  ccr_we,
    input  logic                  jmp_valid,
    input  logic [JSEL_WIDTH-1:0] jmp_sel,
    input  logic                  int_save,
    input  logic                  rti_restore,
    output logic [CCR_WIDTH-1:0]  ccr_out,
    output logic                  branch_taken,
    output logic                  shadow_valid,
    output logic                  shadow_ovf
);

    logic [CCR_WIDTH-1:0] r_ccr;
    logic                 r_ovf;
    logic [CCR_WIDTH-1:0] w_eff;
    logic [CCR_WIDTH-1:0] w_clr_mask;
    logic [CCR_WIDTH-1:0] w_nxt;
    logic                 w_taken;

    // Forwarding lets a jump right after an ALU op test that op's flags.
    assign w_eff = ccr_we ? alu_ccr : r_ccr;

    always_comb begin
        w_clr_mask          = '0;
        w_taken             = jmp_valid & w_eff[jmp_sel] & ~stall & ~rti_restore & ~rst;
        w_clr_mask[jmp_sel] = w_taken;
        w_nxt               = w_eff & ~w_clr_mask;
    end

    assign branch_taken = w_taken;
    assign ccr_out      = r_ccr;
    assign shadow_ovf   = r_ovf;

`ifdef CCR_SHADOW_STACK_EN
    // Pointer counts held entries; one extra bit distinguishes full from empty.
    localparam int                PTR_W = $clog2(SHADOW_DEPTH) + 1;
    localparam logic [PTR_W-1:0]  FULL  = PTR_W'(SHADOW_DEPTH);

    logic [CCR_WIDTH-1:0] r_stack [SHADOW_DEPTH];
    logic [PTR_W-1:0]     r_ptr;
    logic [PTR_W-1:0]     w_ptr_m1;

    assign w_ptr_m1     = r_ptr - 1'b1;
    assign shadow_valid = (r_ptr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ccr <= '0;
            r_ovf <= 1'b0;
            r_ptr <= '0;
            for (int i = 0; i < SHADOW_DEPTH; i++) begin
                r_stack[i] <= '0;
            end
        end else if (!stall) begin
            if (rti_restore) begin
                if (r_ptr != '0) begin
                    r_ccr <= r_stack[w_ptr_m1[PTR_W-2:0]];
                    r_ptr <= w_ptr_m1;
                end else begin
                    r_ccr <= '0;
                end
            end else begin
                r_ccr <= w_nxt;
                if (int_save) begin
                    if (r_ptr == FULL) begin
                        r_stack[SHADOW_DEPTH-1] <= w_nxt;
                        r_ovf                   <= 1'b1;
                    end else begin
                        r_stack[r_ptr[PTR_W-2:0]] <= w_nxt;
                        r_ptr                     <= r_ptr + 1'b1;
                    end
                end
            end
        end
    end
`else
    logic [CCR_WIDTH-1:0] r_shadow;
    logic                 r_shadow_valid;

    assign shadow_valid = r_shadow_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ccr          <= '0;
            r_ovf          <= 1'b0;
            r_shadow       <= '0;
            r_shadow_valid <= 1'b0;
        end else if (!stall) begin
            if (rti_restore) begin
                r_ccr          <= r_shadow_valid ? r_shadow : '0;
                r_shadow_valid <= 1'b0;
            end else begin
                r_ccr <= w_nxt;
                if (int_save) begin
                    // The shadow captures the value committed on this same edge.
                    r_shadow       <= w_nxt;
                    r_shadow_valid <= 1'b1;
                    if (r_shadow_valid) begin
                        r_ovf <= 1'b1;
                    end
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_ccr_flag_unit.sv
// Directed bench for ccr_flag_unit; expected values are hand-computed constants.
module tb_ccr_flag_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall;
  logic [3:0] alu_ccr;
  logic       ccr_we;
  logic       jmp_valid;
  logic [1:0] jmp_sel;
  logic       int_save;
  logic       rti_restore;
  logic [3:0] ccr_out;
  logic       branch_taken;
  logic       shadow_valid;
  logic       shadow_ovf;

  int n_checks = 0;
  int n_pass   = 0;

  // valid/ready does not apply: every input is sampled on each unstalled rising edge.
  ccr_flag_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .alu_ccr(alu_ccr), .ccr_we(ccr_we),
    .jmp_valid(jmp_valid), .jmp_sel(jmp_sel), .int_save(int_save),
    .rti_restore(rti_restore), .ccr_out(ccr_out), .branch_taken(branch_taken),
    .shadow_valid(shadow_valid), .shadow_ovf(shadow_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  task automatic idle();
    stall = 0; alu_ccr = 0; ccr_we = 0; jmp_valid = 0; jmp_sel = 0;
    int_save = 0; rti_restore = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [3:0] v, input logic save);
    idle(); ccr_we = 1; alu_ccr = v; int_save = save;
    tick();
    idle();
  endtask

  task automatic restore();
    idle(); rti_restore = 1;
    tick();
    idle();
  endtask

  initial begin
    idle();
    rst = 1;
    ccr_we = 1; alu_ccr = 4'b0001; jmp_valid = 1;
    #12;
    check("reset_ccr", ccr_out, 0);
    check("reset_sv", shadow_valid, 0);
    check("reset_ovf", shadow_ovf, 0);
    check("reset_bt", branch_taken, 0);
    idle();
    #1 rst = 0;
    tick();

    // Forwarded jump: Z from this cycle's ALU result is tested and cleared
    ccr_we = 1; alu_ccr = 4'b0001; jmp_valid = 1; jmp_sel = 2'b00;
    #1 check("fwd_bt", branch_taken, 1);
    tick(); idle();
    check("fwd_ccr", ccr_out, 4'b0000);

    commit(4'b0100, 0);
    check("load_0100", ccr_out, 4'b0100);
    jmp_valid = 1; jmp_sel = 2'b01;
    #1 check("jn_not_taken", branch_taken, 0);
    tick();
    check("jn_ccr_hold", ccr_out, 4'b0100);
    jmp_sel = 2'b10;
    #1 check("jc_taken", branch_taken, 1);
    tick(); idle();
    check("jc_ccr_clr", ccr_out, 4'b0000);

    // JV taken clears only V
    ccr_we = 1; alu_ccr = 4'b1111; jmp_valid = 1; jmp_sel = 2'b11;
    #1 check("jv_taken", branch_taken, 1);
    tick(); idle();
    check("jv_ccr", ccr_out, 4'b0111);

    // Save/restore with alu_ccr ignored on the RTI edge
    commit(4'b0110, 0);
    commit(4'b1001, 1);
    check("save_ccr", ccr_out, 4'b1001);
    check("save_sv", shadow_valid, 1);
    commit(4'b0000, 0);
    check("mid_ccr", ccr_out, 4'b0000);
    rti_restore = 1; ccr_we = 1; alu_ccr = 4'b1111; jmp_valid = 1; jmp_sel = 2'b00;
    #1 check("rti_bt_suppr", branch_taken, 0);
    tick(); idle();
    check("rti_ccr", ccr_out, 4'b1001);
    check("rti_sv", shadow_valid, 0);
    check("rti_ovf", shadow_ovf, 0);

    // Stall freezes everything, including a pending save
    commit(4'b0011, 1);
    stall = 1; ccr_we = 1; alu_ccr = 4'b1010; jmp_valid = 1; jmp_sel = 2'b00; int_save = 1;
    #1 check("stall_bt", branch_taken, 0);
    tick(); tick(); tick();
    check("stall_ccr", ccr_out, 4'b0011);
    check("stall_sv", shadow_valid, 1);
    check("stall_ovf", shadow_ovf, 0);
    idle();
    commit(4'b1100, 0);
    restore();
    check("stall_shadow", ccr_out, 4'b0011);
    restore();
    check("pop_empty_ccr", ccr_out, 4'b0000);
    check("pop_empty_sv", shadow_valid, 0);

    // Saved value is the post-jump committed value (Z cleared)
    ccr_we = 1; alu_ccr = 4'b0101; jmp_valid = 1; jmp_sel = 2'b00; int_save = 1;
    tick(); idle();
    check("save_jmp_ccr", ccr_out, 4'b0100);
    restore();
    check("save_jmp_rest", ccr_out, 4'b0100);

`ifdef CCR_SHADOW_STACK_EN
    for (int k = 1; k <= 4; k++) commit(4'(k), 1);
    for (int k = 4; k >= 1; k--) begin
      restore();
      check($sformatf("lifo_%0d", k), ccr_out, 8'(k));
    end
    check("lifo_sv", shadow_valid, 0);
    check("lifo_ovf", shadow_ovf, 0);
    for (int k = 1; k <= 4; k++) commit(4'(k), 1);
    check("full_ovf_clear", shadow_ovf, 0);
    commit(4'd5, 1);
    check("full_ovf_set", shadow_ovf, 1);
    restore();
    check("full_top_over", ccr_out, 4'd5);
    restore();
    check("full_next", ccr_out, 4'd3);
`else
    commit(4'b0001, 1);
    check("ovf_first", shadow_ovf, 0);
    commit(4'b0010, 1);
    check("ovf_second", shadow_ovf, 1);
    restore();
    check("ovf_overwrite", ccr_out, 4'b0010);
    check("ovf_sticky", shadow_ovf, 1);
    check("ovf_sv", shadow_valid, 0);
`endif

    // Async reset between edges
    commit(4'b1111, 1);
    check("pre_rst_ccr", ccr_out, 4'b1111);
    check("pre_rst_sv", shadow_valid, 1);
    #1 rst = 1;
    #1;
    check("arst_ccr", ccr_out, 0);
    check("arst_sv", shadow_valid, 0);
    check("arst_ovf", shadow_ovf, 0);
    #1 rst = 0;
    tick();
    check("post_rst_ccr", ccr_out, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
